leaf_mu_window_acc: RTL and testbench

//   Downstream stage of leaf_lambda: consumes its data_out word stream and sums

---
 rtl/leaf_mu_window_acc.sv | 133 +++++++++++++
 tb/tb_leaf_mu_window_acc.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_mu_window_acc.sv
// rtl/leaf_mu_window_acc.sv - sums fixed windows of accepted words and hands each sum off over valid/ready
// Optional LEAF_MU_MAX_EN adds max_out, the unsigned maximum of each completed window.
module leaf_mu_window_acc #(
    parameter int  WIDTH  = 32,
    parameter int  WINDOW = 8,
    localparam int CNT_W  = $clog2(WINDOW),
    localparam int SUM_W  = WIDTH + $clog2(WINDOW)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] sum_out,
    output logic [15:0]      win_count
`ifdef LEAF_MU_MAX_EN
    ,
    output logic [WIDTH-1:0] max_out
`endif
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [SUM_W-1:0] data_ext;
    logic             accept;
    logic             fire;
    logic             load_out;

    // A stalled HOLD still admits a sample when the consumer is taking the sum this cycle.
    assign in_ready = (state == ST_ACC) | out_ready;
    assign accept   = in_valid & in_ready;
    assign fire     = out_valid & out_ready;
    assign data_ext = {{(SUM_W - WIDTH){1'b0}}, data_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ACC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        load_out   = 1'b0;
        case (state)
            ST_ACC: begin
                if (accept) begin
                    if (cnt == CNT_LAST) begin
                        load_out   = 1'b1;
                        acc_next   = '0;
                        cnt_next   = '0;
                        state_next = ST_HOLD;
                    end else begin
                        acc_next = acc + data_ext;
                        cnt_next = cnt + CNT_ONE;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_next = ST_ACC;
                    if (accept) begin
                        acc_next = data_ext;
                        cnt_next = CNT_ONE;
                    end
                end
            end
            default: state_next = ST_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            sum_out   <= '0;
            win_count <= '0;
        end else begin
            acc <= acc_next;
            cnt <= cnt_next;
            if (load_out) begin
                out_valid <= 1'b1;
                sum_out   <= acc + data_ext;
                win_count <= win_count + 16'd1;
            end else if (fire) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef LEAF_MU_MAX_EN
    logic [WIDTH-1:0] max_acc;
    logic [WIDTH-1:0] max_merged;
    logic             first_sample;

    // The first sample of a window either arrives in ACC with cnt==0 or rides the HOLD handoff.
    assign first_sample = (state == ST_HOLD) | (cnt == '0);
    assign max_merged   = (data_in > max_acc) ? data_in : max_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            max_acc <= '0;
            max_out <= '0;
        end else begin
            if (accept) begin
                max_acc <= first_sample ? data_in : max_merged;
            end
            if (load_out) begin
                max_out <= max_merged;
            end
        end
    end
`endif

endmodule

// File: tb/tb_leaf_mu_window_acc.sv
// tb/tb_leaf_mu_window_acc.sv - table, directed and randomized checks of leaf_mu_window_acc
module tb_leaf_mu_window_acc;

    localparam int WIDTH  = 32;
    localparam int WINDOW = 8;
    localparam int SUM_W  = WIDTH + $clog2(WINDOW);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] sum_out;
    logic [15:0]      win_count;
`ifdef LEAF_MU_MAX_EN
    logic [WIDTH-1:0] max_out;
`endif

    leaf_mu_window_acc #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .win_count (win_count)
`ifdef LEAF_MU_MAX_EN
        ,
        .max_out   (max_out)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic [31:0] d;
        logic        ev;
        logic        eir;
        logic [63:0] esum;
        logic [15:0] ewc;
    } vec_t;

    vec_t tbl[23];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic [WIDTH-1:0] d);
        in_valid  = iv;
        out_ready = ordy;
        data_in   = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, '0);
        tick();
        tick();
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_sum_out", 64'(sum_out), 64'd0);
        chk("reset_win_count", {48'd0, win_count}, 64'd0);
        rst = 1'b0;
        tick();
        #2;
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    endtask

    int s6[8] = '{3, 9, 2, 7, 1, 0, 4, 5};

    task automatic feed_s6(input bit gaps);
        for (int k = 0; k < 8; k++) begin
            if (gaps) begin
                int g = $urandom_range(0, 2);
                for (int j = 0; j < g; j++) begin
                    drive(1'b0, 1'b1, $urandom);
                    tick();
                end
            end
            drive(1'b1, 1'b1, WIDTH'(s6[k]));
            tick();
        end
        drive(1'b0, 1'b0, '0);
        #2;
        chk("max_win_out_valid", {63'd0, out_valid}, 64'd1);
        chk("max_win_sum", 64'(sum_out), 64'd31);
`ifdef LEAF_MU_MAX_EN
        chk("max_win_max_out", 64'(max_out), 64'd9);
`endif
        drive(1'b0, 1'b1, '0);
        tick();
    endtask

    // Reference model state: accepted samples of the open window and one pending result.
    logic [WIDTH-1:0] win_q[$];
    bit               pend;
    logic [63:0]      pend_sum;
    logic [63:0]      pend_max;
    logic [15:0]      wc_m;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 23; i++) begin
            tbl[i] = '{iv: 1'b0, ordy: 1'b0, d: 32'd0, ev: 1'b0, eir: 1'b1, esum: 64'd0, ewc: 16'd0};
        end
        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{iv: 1'b1, ordy: 1'b1, d: 32'(i + 1), ev: 1'b0, eir: 1'b1, esum: 64'd0, ewc: 16'd0};
        end
        tbl[8] = '{iv: 1'b0, ordy: 1'b0, d: 32'd0, ev: 1'b1, eir: 1'b0, esum: 64'd36, ewc: 16'd1};
        for (int i = 9; i < 13; i++) begin
            tbl[i] = '{iv: 1'b1, ordy: 1'b0, d: 32'd77, ev: 1'b1, eir: 1'b0, esum: 64'd36, ewc: 16'd1};
        end
        tbl[13] = '{iv: 1'b1, ordy: 1'b1, d: 32'd5, ev: 1'b1, eir: 1'b1, esum: 64'd36, ewc: 16'd1};
        for (int i = 14; i < 21; i++) begin
            tbl[i] = '{iv: 1'b1, ordy: 1'b1, d: 32'd1, ev: 1'b0, eir: 1'b1, esum: 64'd36, ewc: 16'd1};
        end
        tbl[21] = '{iv: 1'b0, ordy: 1'b1, d: 32'd0, ev: 1'b1, eir: 1'b1, esum: 64'd12, ewc: 16'd2};
        tbl[22] = '{iv: 1'b0, ordy: 1'b0, d: 32'd0, ev: 1'b0, eir: 1'b1, esum: 64'd12, ewc: 16'd2};

        rst = 1'b1;
        drive(1'b0, 1'b0, '0);
        tick();
        do_reset();

        // Window of 1..8, five stalled cycles, handoff with a concurrent first sample of 5.
        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].iv, tbl[i].ordy, tbl[i].d);
            #2;
            chk($sformatf("tbl%0d_out_valid", i), {63'd0, out_valid}, {63'd0, tbl[i].ev});
            chk($sformatf("tbl%0d_in_ready", i), {63'd0, in_ready}, {63'd0, tbl[i].eir});
            chk($sformatf("tbl%0d_sum_out", i), 64'(sum_out), tbl[i].esum);
            chk($sformatf("tbl%0d_win_count", i), {48'd0, win_count}, {48'd0, tbl[i].ewc});
            tick();
        end

        // All-ones window must fit in SUM_W without wrap.
        for (int k = 0; k < WINDOW; k++) begin
            drive(1'b1, 1'b1, '1);
            tick();
        end
        drive(1'b0, 1'b0, '0);
        #2;
        chk("allones_out_valid", {63'd0, out_valid}, 64'd1);
        chk("allones_sum", 64'(sum_out), 64'h7_FFFF_FFF8);
        drive(1'b0, 1'b1, '0);
        tick();

        // Partial window discarded by reset.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, WIDTH'(100));
            tick();
        end
        rst = 1'b1;
        drive(1'b0, 1'b0, '0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < WINDOW; k++) begin
            drive(1'b1, 1'b1, WIDTH'(2));
            tick();
        end
        drive(1'b0, 1'b0, '0);
        #2;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd1);
        chk("midrst_sum", 64'(sum_out), 64'd16);
        chk("midrst_win_count", {48'd0, win_count}, 64'd1);
        drive(1'b0, 1'b1, '0);
        tick();

        feed_s6(1'b0);
        feed_s6(1'b1);

        // Randomized traffic against the queue-based model.
        do_reset();
        pend = 1'b0;
        wc_m = 16'd0;
        win_q.delete();
        for (int c = 0; c < 3000; c++) begin
            logic             iv;
            logic             ordy;
            logic [WIDTH-1:0] d;
            logic             exp_ir;
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            d    = ($urandom_range(0, 7) == 0) ? '1 : WIDTH'($urandom);
            drive(iv, ordy, d);
            #2;
            exp_ir = !pend || ordy;
            chk("rnd_in_ready", {63'd0, in_ready}, {63'd0, exp_ir});
            chk("rnd_out_valid", {63'd0, out_valid}, {63'd0, pend});
            chk("rnd_win_count", {48'd0, win_count}, {48'd0, wc_m});
            if (pend && ordy) begin
                chk("rnd_sum", 64'(sum_out), pend_sum);
`ifdef LEAF_MU_MAX_EN
                chk("rnd_max", 64'(max_out), pend_max);
`endif
                pend = 1'b0;
            end
            if (iv && exp_ir) begin
                win_q.push_back(d);
                if (win_q.size() == WINDOW) begin
                    pend_sum = 64'd0;
                    pend_max = 64'd0;
                    foreach (win_q[k]) begin
                        pend_sum = pend_sum + 64'(win_q[k]);
                        if (64'(win_q[k]) > pend_max) pend_max = 64'(win_q[k]);
                    end
                    pend = 1'b1;
                    wc_m = wc_m + 16'd1;
                    win_q.delete();
                end
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
